// File: rtl/seq_pkg.sv
// Shared types for the sequenced pattern generator: FSM state encoding and run modes.
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } seq_state_e;

  typedef enum logic {
    ModeOneShot = 1'b0,
    ModeLoop    = 1'b1
  } seq_mode_e;

endpackage

// File: rtl/seq_dwell_cnt.sv
// Per-step dwell countdown: load a value, count down while enabled, flag zero.
module seq_dwell_cnt #(
  parameter int unsigned HW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [HW-1:0] load_val_i,
  output logic          zero_o
);

  logic [HW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - HW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Steps through a programmable table of patterns, holding each for its own dwell time,
// in one-shot or loop mode with pause and abort.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int unsigned    DEPTH    = 4,
  parameter int unsigned    DW       = 1,
  parameter int unsigned    HW       = 4,
  parameter logic [DW-1:0]  IDLE_VAL = '0,
  localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          pause_i,
  input  logic          mode_i,
  input  logic          cfg_we_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [DW-1:0] cfg_pat_i,
  input  logic [HW-1:0] cfg_dwell_i,
  output logic [DW-1:0] out_o,
  output logic [AW-1:0] step_o,
  output logic          busy_o,
  output logic          done_o
);

  seq_state_e    state_q;
  seq_mode_e     mode_q;
  logic [AW-1:0] step_q;
  logic [DW-1:0] out_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] pat_q   [DEPTH];
  logic [HW-1:0] dwell_q [DEPTH];

  logic          start_go;
  logic          run_tick;
  logic          cnt_zero;
  logic          last_step;
  logic [AW-1:0] next_step;
  logic          cnt_load;
  logic [HW-1:0] cnt_load_val;
  logic          cfg_wr;

  always_comb begin
    start_go  = (state_q == StIdle) && start_i && !stop_i;
    // A PAUSE cycle with pause_i low counts like RUN, so the remaining dwell is exact.
    run_tick  = ((state_q == StRun) || (state_q == StPause)) && !stop_i && !pause_i;
    last_step = (step_q == AW'(DEPTH - 1));
    next_step = last_step ? '0 : step_q + AW'(1);
    cnt_load  = start_go || (run_tick && cnt_zero);
    cnt_load_val = start_go ? dwell_q[0] : dwell_q[next_step];
    cfg_wr    = cfg_we_i && !busy_q && (32'(cfg_addr_i) < DEPTH);
  end

  seq_dwell_cnt #(
    .HW (HW)
  ) u_dwell_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (cnt_load),
    .en_i       (run_tick),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      mode_q  <= ModeOneShot;
      step_q  <= '0;
      out_q   <= IDLE_VAL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i]   <= '0;
        dwell_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (cfg_wr) begin
        pat_q[cfg_addr_i]   <= cfg_pat_i;
        dwell_q[cfg_addr_i] <= cfg_dwell_i;
      end
      case (state_q)
        StIdle: begin
          if (start_go) begin
            state_q <= StRun;
            mode_q  <= seq_mode_e'(mode_i);
            step_q  <= '0;
            out_q   <= pat_q[0];
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun, StPause: begin
          if (stop_i) begin
            state_q <= StIdle;
            step_q  <= '0;
            out_q   <= IDLE_VAL;
            busy_q  <= 1'b0;
          end else if (pause_i) begin
            state_q <= StPause;
          end else begin
            state_q <= StRun;
            if (cnt_zero) begin
              if (last_step) begin
                done_q <= 1'b1;
                step_q <= '0;
                if (mode_q == ModeLoop) begin
                  out_q <= pat_q[0];
                end else begin
                  state_q <= StIdle;
                  out_q   <= IDLE_VAL;
                  busy_q  <= 1'b0;
                end
              end else begin
                step_q <= next_step;
                out_q  <= pat_q[next_step];
              end
            end
          end
        end
        default: begin
          state_q <= StIdle;
          step_q  <= '0;
          out_q   <= IDLE_VAL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_o  = out_q;
  assign step_o = step_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen with DEPTH=4, DW=1, HW=4, IDLE_VAL=0.
module tb_seq_pattern_gen;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 1;
  localparam int unsigned HW    = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, pause, mode, cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_pat;
  logic [HW-1:0] cfg_dwell;
  logic [DW-1:0] out;
  logic [AW-1:0] step;
  logic          busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .DEPTH    (DEPTH),
    .DW       (DW),
    .HW       (HW),
    .IDLE_VAL (1'b0)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .stop_i      (stop),
    .pause_i     (pause),
    .mode_i      (mode),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_pat_i   (cfg_pat),
    .cfg_dwell_i (cfg_dwell),
    .out_o       (out),
    .step_o      (step),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int o, input int s, input int b, input int d);
    chk({tag, ".out"},  32'(out),  32'(o));
    chk({tag, ".step"}, 32'(step), 32'(s));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic cfg_wr(input int a, input int p, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_pat   = DW'(p);
    cfg_dwell = HW'(d);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic load_cfg(input int p0, input int p1, input int p2, input int p3,
                          input int d0, input int d1, input int d2, input int d3);
    cfg_wr(0, p0, d0);
    cfg_wr(1, p1, d1);
    cfg_wr(2, p2, d2);
    cfg_wr(3, p3, d3);
  endtask

  // Start edge ("edge 0"); outputs are checked 1 time unit after it.
  task automatic do_start(input logic m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int sx[7];
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_pat = '0; cfg_dwell = '0;
    #2;
    chk_all("reset", 0, 0, 0, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk_all("post_reset_idle", 0, 0, 0, 0);

    // One-shot 0,1,0,1 with zero dwell
    load_cfg(0, 1, 0, 1, 0, 0, 0, 0);
    do_start(1'b0);
    chk_all("os_e0", 0, 0, 1, 0);
    for (int e = 1; e < 4; e++) begin
      tick();
      chk_all($sformatf("os_e%0d", e), e % 2, e, 1, 0);
    end
    tick();
    chk_all("os_e4", 0, 0, 0, 1);
    tick();
    chk_all("os_e5", 0, 0, 0, 0);

    // Loop, mode_i dropped after start (must stay latched), stop at edge 6
    do_start(1'b1);
    mode = 1'b0;
    chk_all("lp_e0", 0, 0, 1, 0);
    for (int e = 1; e < 6; e++) begin
      tick();
      chk_all($sformatf("lp_e%0d", e), e % 2, e % 4, 1, (e == 4) ? 1 : 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("lp_stop", 0, 0, 0, 0);
    tick();
    chk_all("lp_after_stop", 0, 0, 0, 0);

    // Dwell {2,0,1,0}: step trace 0,0,0,1,2,2,3 then done
    load_cfg(0, 1, 0, 1, 2, 0, 1, 0);
    sx = '{0, 0, 0, 1, 2, 2, 3};
    do_start(1'b0);
    chk("dw_e0.step", 32'(step), 32'(sx[0]));
    for (int e = 1; e < 7; e++) begin
      tick();
      chk($sformatf("dw_e%0d.step", e), 32'(step), 32'(sx[e]));
      chk($sformatf("dw_e%0d.done", e), 32'(done), 32'd0);
    end
    tick();
    chk_all("dw_e7", 0, 0, 0, 1);

    // Pause 5 cycles inside a 4-cycle step 0; start_i asserted meanwhile is ignored
    load_cfg(0, 1, 0, 1, 3, 0, 0, 0);
    do_start(1'b0);
    tick();
    chk_all("ps_e1", 0, 0, 1, 0);
    pause = 1'b1;
    start = 1'b1;
    for (int e = 2; e < 7; e++) begin
      tick();
      chk_all($sformatf("ps_e%0d", e), 0, 0, 1, 0);
    end
    pause = 1'b0;
    start = 1'b0;
    tick();
    chk_all("ps_e7", 0, 0, 1, 0);
    tick();
    chk_all("ps_e8", 0, 0, 1, 0);
    tick();
    chk_all("ps_e9", 1, 1, 1, 0);
    tick();
    chk_all("ps_e10", 0, 2, 1, 0);
    tick();
    chk_all("ps_e11", 1, 3, 1, 0);
    tick();
    chk_all("ps_e12", 0, 0, 0, 1);

    // Stop while paused: idle, no done
    load_cfg(1, 1, 0, 1, 0, 0, 0, 0);
    do_start(1'b0);
    chk_all("sp_e0", 1, 0, 1, 0);
    pause = 1'b1;
    tick();
    chk_all("sp_paused", 1, 0, 1, 0);
    stop = 1'b1;
    tick();
    chk_all("sp_stop", 0, 0, 0, 0);
    stop = 1'b0;
    pause = 1'b0;
    tick();
    chk_all("sp_after", 0, 0, 0, 0);

    // start_i together with stop_i in idle stays idle
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk_all("start_stop_idle", 0, 0, 0, 0);

    // Config write while busy is ignored across two passes
    load_cfg(0, 1, 0, 1, 0, 0, 0, 0);
    do_start(1'b1);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_pat = 1'b0; cfg_dwell = 4'd5;
    for (int e = 1; e < 9; e++) begin
      tick();
      chk($sformatf("bw_e%0d.out", e), 32'(out), 32'(e % 2));
      chk($sformatf("bw_e%0d.step", e), 32'(step), 32'(e % 4));
    end
    cfg_we = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("bw_stop", 0, 0, 0, 0);

    // Same write while idle takes effect on the next start
    cfg_wr(1, 0, 0);
    do_start(1'b0);
    chk_all("iw_e0", 0, 0, 1, 0);
    tick();
    chk_all("iw_e1", 0, 1, 1, 0);
    tick();
    chk_all("iw_e2", 0, 2, 1, 0);
    tick();
    chk_all("iw_e3", 1, 3, 1, 0);
    tick();
    chk_all("iw_e4", 0, 0, 0, 1);

    // Asynchronous reset in the middle of step 2
    load_cfg(0, 1, 1, 0, 0, 0, 3, 0);
    do_start(1'b0);
    tick();
    tick();
    chk_all("rs_e2", 1, 2, 1, 0);
    tick();
    chk_all("rs_e3", 1, 2, 1, 0);
    #3 rst_n = 1'b0;
    #1;
    chk_all("rs_async", 0, 0, 0, 0);
    tick();
    chk_all("rs_held", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk_all("rs_wait_idle", 0, 0, 0, 0);
    // Table zeroed: all-zero pattern, one cycle per step
    do_start(1'b0);
    chk_all("rz_e0", 0, 0, 1, 0);
    for (int e = 1; e < 4; e++) begin
      tick();
      chk_all($sformatf("rz_e%0d", e), 0, e, 1, 0);
    end
    tick();
    chk_all("rz_e4", 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
